// File: rtl/gpio_bus_pkg.sv
// gpio_bus_pkg: shared state encoding, default timing and emulator register map
package gpio_bus_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;
  localparam int SETUP_CYC_DEF = 1;
  localparam int STROBE_CYC_DEF = 2;
  localparam int HOLD_CYC_DEF = 1;
  localparam logic [15:0] GPIO_REG0_ADDR = 16'h6B00;
  localparam logic [15:0] GPIO_REG1_ADDR = 16'hDB00;
  function automatic int max3(input int a, input int b, input int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
endpackage

// File: rtl/gpio_bus_rr_arb.sv
// gpio_bus_rr_arb: 2-way round-robin arbiter; priority flips to the loser on each advance
module gpio_bus_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_valid,
  input  logic       i_adv,
  output logic [1:0] o_gnt,
  output logic       o_pri
);
  logic r_pri;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_pri <= 1'b0;
    else if (i_adv) r_pri <= ~o_gnt[1];
  always_comb o_gnt = (&i_valid) ? (r_pri ? 2'b10 : 2'b01) : i_valid;
  assign o_pri = r_pri;
endmodule

// File: rtl/gpio_bus_ctrl.sv
// gpio_bus_ctrl: two-master sequencer for the emulator strobe bus with setup/strobe/hold phases
module gpio_bus_ctrl
  import gpio_bus_pkg::*;
#(
  parameter int SETUP_CYC  = SETUP_CYC_DEF,
  parameter int STROBE_CYC = STROBE_CYC_DEF,
  parameter int HOLD_CYC   = HOLD_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m1_valid,
  input  logic        m0_write,
  input  logic        m1_write,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m1_addr,
  input  logic [31:0] m0_wdata,
  input  logic [31:0] m1_wdata,
  output logic        m0_ready,
  output logic        m1_ready,
  output logic        m0_rsp_valid,
  output logic        m1_rsp_valid,
  output logic [31:0] m0_rdata,
  output logic [31:0] m1_rdata,
  output logic [15:0] saddress,
  output logic        srd,
  output logic        swr,
  output logic [31:0] sdata_in,
  input  logic [31:0] sdata_out,
  output logic        busy,
  output logic        grant
);
  localparam int CW = $clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC) + 1);
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt, w_load;
  logic [1:0] w_gnt;
  logic w_pri, w_adv, w_last, w_act, r_seen, r_write;
  logic [15:0] r_addr;
  logic [31:0] r_wdata, r_cap, r_rdata0, r_rdata1, w_rsp_data;
  gpio_bus_rr_arb u_arb (
    .clk(clk), .rst(reset), .i_valid({m1_valid, m0_valid}), .i_adv(w_adv),
    .o_gnt(w_gnt), .o_pri(w_pri)
  );
  assign w_adv = (r_state == IDLE) && (m0_valid || m1_valid);
  assign w_last = r_cnt == CW'(1);
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = w_adv ? SETUP : IDLE;
      SETUP:   w_next = w_last ? STROBE : SETUP;
      STROBE:  w_next = w_last ? HOLD : STROBE;
      HOLD:    w_next = w_last ? DONE : HOLD;
      default: w_next = IDLE;
    endcase
    w_load = (w_next == SETUP) ? CW'(SETUP_CYC) : (w_next == STROBE) ? CW'(STROBE_CYC) : CW'(HOLD_CYC);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  // The arbiter's priority already remembers the last winner, so grant only needs a "has ever granted" flag.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_cnt <= '0;
      r_seen <= 1'b0;
      r_write <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_cap <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_cnt <= (w_next != r_state) ? w_load : r_cnt - CW'(|r_cnt);
      if (w_adv) begin
        r_seen <= 1'b1;
        r_write <= w_gnt[1] ? m1_write : m0_write;
        r_addr <= w_gnt[1] ? m1_addr : m0_addr;
        r_wdata <= w_gnt[1] ? m1_wdata : m0_wdata;
      end
      if (r_state == STROBE && w_last && !r_write) r_cap <= sdata_out;
      if (r_state == HOLD && w_last && !grant) r_rdata0 <= w_rsp_data;
      if (r_state == HOLD && w_last && grant) r_rdata1 <= w_rsp_data;
    end
  assign w_rsp_data = r_write ? 32'h0 : r_cap;
  assign w_act = (r_state == SETUP) || (r_state == STROBE) || (r_state == HOLD);
  assign m0_ready = (r_state == IDLE) && w_gnt[0];
  assign m1_ready = (r_state == IDLE) && w_gnt[1];
  assign saddress = w_act ? r_addr : 16'h0;
  assign sdata_in = (w_act && r_write) ? r_wdata : 32'h0;
  assign srd = (r_state == STROBE) && !r_write;
  assign swr = (r_state == STROBE) && r_write;
  assign busy = r_state != IDLE;
  assign grant = r_seen && !w_pri;
  assign m0_rsp_valid = (r_state == DONE) && !grant;
  assign m1_rsp_valid = (r_state == DONE) && grant;
  assign m0_rdata = r_rdata0;
  assign m1_rdata = r_rdata1;
endmodule

// File: tb/tb_gpio_bus_ctrl.sv
// tb_gpio_bus_ctrl: directed checks of bus timing, arbitration, reset abort and timing parameters
module tb_gpio_bus_ctrl;
  import gpio_bus_pkg::*;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  logic m0_valid, m1_valid, m0_write, m1_write, m0_ready, m1_ready;
  logic m0_rsp_valid, m1_rsp_valid, srd, swr, busy, grant;
  logic [15:0] m0_addr, m1_addr, saddress;
  logic [31:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, sdata_in, sdata_out;
  logic p_m0_valid, p_m1_valid, p_m0_write, p_m1_write, p_m0_ready, p_m1_ready;
  logic p_m0_rsp_valid, p_m1_rsp_valid, p_srd, p_swr, p_busy, p_grant;
  logic [15:0] p_m0_addr, p_m1_addr, p_saddress;
  logic [31:0] p_m0_wdata, p_m1_wdata, p_m0_rdata, p_m1_rdata, p_sdata_in;
  int checks = 0;
  int errors = 0;

  gpio_bus_ctrl dut (
    .clk(clk), .reset(reset),
    .m0_valid(m0_valid), .m1_valid(m1_valid), .m0_write(m0_write), .m1_write(m1_write),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_ready(m0_ready), .m1_ready(m1_ready), .m0_rsp_valid(m0_rsp_valid), .m1_rsp_valid(m1_rsp_valid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .saddress(saddress), .srd(srd), .swr(swr),
    .sdata_in(sdata_in), .sdata_out(sdata_out), .busy(busy), .grant(grant)
  );

  gpio_bus_ctrl #(.SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2)) dut_p (
    .clk(clk), .reset(reset),
    .m0_valid(p_m0_valid), .m1_valid(p_m1_valid), .m0_write(p_m0_write), .m1_write(p_m1_write),
    .m0_addr(p_m0_addr), .m1_addr(p_m1_addr), .m0_wdata(p_m0_wdata), .m1_wdata(p_m1_wdata),
    .m0_ready(p_m0_ready), .m1_ready(p_m1_ready), .m0_rsp_valid(p_m0_rsp_valid), .m1_rsp_valid(p_m1_rsp_valid),
    .m0_rdata(p_m0_rdata), .m1_rdata(p_m1_rdata), .saddress(p_saddress), .srd(p_srd), .swr(p_swr),
    .sdata_in(p_sdata_in), .sdata_out(sdata_out), .busy(p_busy), .grant(p_grant)
  );

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    {m0_valid, m1_valid, m0_write, m1_write} = '0;
    {m0_addr, m1_addr, m0_wdata, m1_wdata, sdata_out} = '0;
    {p_m0_valid, p_m1_valid, p_m0_write, p_m1_write} = '0;
    {p_m0_addr, p_m1_addr, p_m0_wdata, p_m1_wdata} = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (grant !== 1'b0) begin errors++; $display("FAIL reset_grant got %b want 0", grant); end
    checks++; if ({srd, swr} !== 2'b00) begin errors++; $display("FAIL reset_strobes got %b want 00", {srd, swr}); end
    checks++; if (saddress !== 16'h0) begin errors++; $display("FAIL reset_saddress got %h want 0000", saddress); end
    checks++; if (sdata_in !== 32'h0) begin errors++; $display("FAIL reset_sdata_in got %h want 0", sdata_in); end
    checks++; if ({m0_rsp_valid, m1_rsp_valid, m0_ready, m1_ready} !== 4'b0) begin errors++; $display("FAIL reset_handshake got %b want 0000", {m0_rsp_valid, m1_rsp_valid, m0_ready, m1_ready}); end
    checks++; if ({m0_rdata, m1_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", {m0_rdata, m1_rdata}); end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_write();
    m0_valid = 1'b1; m0_write = 1'b1; m0_addr = GPIO_REG0_ADDR; m0_wdata = 32'h0000_0A00;
    @(negedge clk);
    checks++; if ({m0_ready, m1_ready} !== 2'b10) begin errors++; $display("FAIL wr_ready got %b want 10", {m0_ready, m1_ready}); end
    @(posedge clk);
    #1 m0_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      checks++; if ({swr, srd} !== {(c == 2 || c == 3), 1'b0}) begin errors++; $display("FAIL wr_strobe c%0d got swr/srd %b%b", c, swr, srd); end
      checks++; if (saddress !== (c <= 4 ? 16'h6B00 : 16'h0)) begin errors++; $display("FAIL wr_saddress c%0d got %h", c, saddress); end
      checks++; if (sdata_in !== (c <= 4 ? 32'h0000_0A00 : 32'h0)) begin errors++; $display("FAIL wr_sdata_in c%0d got %h", c, sdata_in); end
      checks++; if ({m0_rsp_valid, m1_rsp_valid} !== {c == 5, 1'b0}) begin errors++; $display("FAIL wr_rsp c%0d got %b%b", c, m0_rsp_valid, m1_rsp_valid); end
      checks++; if (busy !== (c <= 5)) begin errors++; $display("FAIL wr_busy c%0d got %b", c, busy); end
      if (c == 5) begin
        checks++; if (m0_rdata !== 32'h0) begin errors++; $display("FAIL wr_rdata got %h want 0", m0_rdata); end
        checks++; if (grant !== 1'b0) begin errors++; $display("FAIL wr_grant got %b want 0", grant); end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_read();
    sdata_out = 32'h0000_0500;
    m1_valid = 1'b1; m1_write = 1'b0; m1_addr = GPIO_REG0_ADDR; m1_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++; if ({m0_ready, m1_ready} !== 2'b01) begin errors++; $display("FAIL rd_ready got %b want 01", {m0_ready, m1_ready}); end
    @(posedge clk);
    #1 m1_valid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      checks++; if ({srd, swr} !== {(c == 2 || c == 3), 1'b0}) begin errors++; $display("FAIL rd_strobe c%0d got srd/swr %b%b", c, srd, swr); end
      checks++; if (saddress !== (c <= 4 ? 16'h6B00 : 16'h0)) begin errors++; $display("FAIL rd_saddress c%0d got %h", c, saddress); end
      checks++; if (sdata_in !== 32'h0) begin errors++; $display("FAIL rd_sdata_in c%0d got %h want 0", c, sdata_in); end
      checks++; if ({m1_rsp_valid, m0_rsp_valid} !== {c == 5, 1'b0}) begin errors++; $display("FAIL rd_rsp c%0d got %b%b", c, m1_rsp_valid, m0_rsp_valid); end
      if (c == 4) sdata_out = 32'hDEAD_BEEF;
      if (c == 5) begin
        checks++; if (m1_rdata !== 32'h0000_0500) begin errors++; $display("FAIL rd_rdata got %h want 00000500", m1_rdata); end
        checks++; if (grant !== 1'b1) begin errors++; $display("FAIL rd_grant got %b want 1", grant); end
      end
    end
    checks++; if (m1_rdata !== 32'h0000_0500) begin errors++; $display("FAIL rd_rdata_hold got %h want 00000500", m1_rdata); end
    checks++; if (m0_rdata !== 32'h0) begin errors++; $display("FAIL rd_other_rdata got %h want 0", m0_rdata); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_round_robin();
    int n = 0;
    int r0 = 0;
    int r1 = 0;
    logic [3:0] order = '0;
    pulse_reset();
    sdata_out = 32'h0000_1234;
    m0_write = 1'b1; m0_addr = GPIO_REG1_ADDR; m0_wdata = 32'h55;
    m1_write = 1'b0; m1_addr = GPIO_REG0_ADDR;
    m0_valid = 1'b1; m1_valid = 1'b1;
    for (int k = 0; k < 80 && (n < 4 || r0 + r1 < 4); k++) begin
      @(negedge clk);
      if (m0_ready || m1_ready) begin
        checks++; if (m0_ready && m1_ready) begin errors++; $display("FAIL rr_one_ready got %b%b", m0_ready, m1_ready); end
        if (n < 4) order[n] = m1_ready;
        n++;
      end
      r0 += int'(m0_rsp_valid);
      r1 += int'(m1_rsp_valid);
      @(posedge clk);
      #1;
      if (n == 4) begin m0_valid = 1'b0; m1_valid = 1'b0; end
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL rr_accepts got %0d want 4", n); end
    checks++; if (order !== 4'b1010) begin errors++; $display("FAIL rr_order got %b want 1010", order); end
    checks++; if (r0 !== 2 || r1 !== 2) begin errors++; $display("FAIL rr_rsp_count got %0d/%0d want 2/2", r0, r1); end
    checks++; if (m1_rdata !== 32'h0000_1234) begin errors++; $display("FAIL rr_m1_rdata got %h want 00001234", m1_rdata); end
  endtask

  task automatic test_reset_mid();
    int rsp = 0;
    m0_valid = 1'b1; m0_write = 1'b1; m0_addr = GPIO_REG1_ADDR; m0_wdata = 32'h77;
    @(posedge clk);
    #1 m0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (swr !== 1'b1) begin errors++; $display("FAIL mid_swr_high got %b want 1", swr); end
    #1 reset = 1'b1;
    #1;
    checks++; if ({srd, swr} !== 2'b00) begin errors++; $display("FAIL mid_strobes got %b want 00", {srd, swr}); end
    checks++; if (saddress !== 16'h0 || sdata_in !== 32'h0) begin errors++; $display("FAIL mid_bus got %h/%h want 0", saddress, sdata_in); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", busy); end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      rsp += int'(m0_rsp_valid || m1_rsp_valid);
    end
    checks++; if (rsp !== 0) begin errors++; $display("FAIL mid_no_rsp got %0d want 0", rsp); end
    @(posedge clk);
    #1;
    sdata_out = 32'h0000_0BAD;
    m1_valid = 1'b1; m1_write = 1'b0; m1_addr = GPIO_REG0_ADDR;
    @(posedge clk);
    #1 m1_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checks++; if (srd !== (c == 2 || c == 3)) begin errors++; $display("FAIL mid_rd_srd c%0d got %b", c, srd); end
      checks++; if (m1_rsp_valid !== (c == 5)) begin errors++; $display("FAIL mid_rd_rsp c%0d got %b", c, m1_rsp_valid); end
    end
    checks++; if (m1_rdata !== 32'h0000_0BAD) begin errors++; $display("FAIL mid_rd_rdata got %h want 00000bad", m1_rdata); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_params();
    p_m0_valid = 1'b1; p_m0_write = 1'b1; p_m0_addr = GPIO_REG0_ADDR; p_m0_wdata = 32'h3;
    @(negedge clk);
    checks++; if (p_m0_ready !== 1'b1) begin errors++; $display("FAIL prm_ready got %b want 1", p_m0_ready); end
    @(posedge clk);
    #1 p_m0_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checks++; if ({p_swr, p_srd} !== {c == 4, 1'b0}) begin errors++; $display("FAIL prm_strobe c%0d got %b%b", c, p_swr, p_srd); end
      checks++; if (p_saddress !== (c <= 6 ? 16'h6B00 : 16'h0)) begin errors++; $display("FAIL prm_saddress c%0d got %h", c, p_saddress); end
      checks++; if (p_m0_rsp_valid !== (c == 7)) begin errors++; $display("FAIL prm_rsp c%0d got %b", c, p_m0_rsp_valid); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int acc[3] = '{0, 0, 0};
    int n = 0;
    m0_valid = 1'b1; m0_write = 1'b1; m0_addr = GPIO_REG0_ADDR; m0_wdata = 32'h1;
    m1_valid = 1'b0;
    for (int k = 0; k < 40 && n < 3; k++) begin
      @(negedge clk);
      checks++; if (m1_ready !== 1'b0) begin errors++; $display("FAIL b2b_m1_ready k%0d got %b want 0", k, m1_ready); end
      if (m0_ready) begin acc[n] = k; n++; end
      @(posedge clk);
      #1;
      if (n == 3) m0_valid = 1'b0;
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL b2b_accepts got %0d want 3", n); end
    checks++; if (acc[0] !== 0 || acc[1] !== 6 || acc[2] !== 12) begin errors++; $display("FAIL b2b_spacing got %0d,%0d,%0d want 0,6,12", acc[0], acc[1], acc[2]); end
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_reset_mid();
    test_params();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
